// File: rtl/dserial_add64_pkg.sv
// Shared constants and FSM encoding for the digit-serial 64-bit adder.
package dserial_add64_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dserial_add64_if.sv
// Operand/result handshake bundle for dserial_add64.
interface dserial_add64_if
    import dserial_add64_pkg::*;
#(
    parameter int NWORDS = 4
);
    localparam int W = SLICE_W * NWORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/dserial_add64_cska16.sv
// 16-bit carry-skip adder: four 4-bit ripple blocks, each bypassed when fully propagating.
module cska16 (
    output logic [15:0] sum,
    output logic        cout,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin
);

    logic [15:0] p;
    logic [15:0] g;
    logic [4:0]  bc;

    assign p     = a ^ b;
    assign g     = a & b;
    assign bc[0] = cin;

    for (genvar k = 0; k < 4; k++) begin : g_blk
        logic [4:0] rc;
        assign rc[0] = bc[k];
        for (genvar i = 0; i < 4; i++) begin : g_bit
            assign sum[4*k+i] = p[4*k+i] ^ rc[i];
            assign rc[i+1]    = g[4*k+i] | (p[4*k+i] & rc[i]);
        end
        // Skip path: an all-propagate block forwards its incoming carry directly.
        assign bc[k+1] = (&p[4*k +: 4]) ? bc[k] : rc[4];
    end

    assign cout = bc[4];

endmodule

// File: rtl/dserial_add64.sv
// Digit-serial multi-word add/subtract: one cska16 slice per cycle, LSW first.
module dserial_add64
    import dserial_add64_pkg::*;
#(
    parameter int NWORDS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    dserial_add64_if.slave  bus
);

    localparam int W  = SLICE_W * NWORDS;
    localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int BW = $clog2(W);

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       cnt;
    logic [BW-1:0]       base;
    logic                last;
    logic [W-1:0]        opa;
    logic [W-1:0]        opb;
    logic                carry;
    logic [W-1:0]        sum_r;
    logic                cout_r;
    logic                ovf_r;
    logic [SLICE_W-1:0]  s_sum;
    logic                s_cout;

    assign base = BW'({cnt, 4'b0000});
    assign last = (cnt == CW'(NWORDS - 1));

    cska16 u_cska16 (
        .sum  (s_sum),
        .cout (s_cout),
        .a    (opa[base +: SLICE_W]),
        .b    (opb[base +: SLICE_W]),
        .cin  (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = RUN;
            RUN:     if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            carry  <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        opa   <= bus.a;
                        opb   <= bus.sub ? ~bus.b : bus.b;
                        carry <= bus.sub | bus.cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sum_r[base +: SLICE_W] <= s_sum;
                    carry                  <= s_cout;
                    cnt                    <= cnt + CW'(1);
                    // Overflow uses the operand sign bits still held in opa/opb.
                    if (last) begin
                        cout_r <= s_cout;
                        ovf_r  <= (opa[W-1] == opb[W-1]) && (s_sum[SLICE_W-1] != opa[W-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_dserial_add64.sv
// Directed self-checking bench for dserial_add64 (NWORDS=4).
module tb_dserial_add64;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    dserial_add64_if #(.NWORDS(4)) bus ();

    dserial_add64 #(.NWORDS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [63:0] a, input logic [63:0] b,
                            input logic cin, input logic sub);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 64'hDEAD_BEEF_0BAD_F00D;
        bus.b        = 64'h1234_5678_9ABC_DEF0;
        bus.cin      = 1'b1;
        bus.sub      = 1'b1;
    endtask

    task automatic wait_result(input string tag);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        for (int k = 1; k <= 12 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                seen = 1'b1;
                n    = k;
            end
        end
        chk({tag, "_lat"}, 64'(n), 64'd4);
    endtask

    task automatic check_res(input string tag, input logic [63:0] s,
                             input logic c, input logic o);
        chk({tag, "_sum"},  bus.sum, s);
        chk({tag, "_cout"}, 64'(bus.cout), 64'(c));
        chk({tag, "_ovf"},  64'(bus.ovf), 64'(o));
    endtask

    task automatic release_res(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
        chk({tag, "_ovld"}, 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic sub,
                          input logic [63:0] s, input logic c, input logic o);
        start_op(a, b, cin, sub);
        wait_result(tag);
        check_res(tag, s, c, o);
        release_res(tag);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;

        #12;
        chk("rst_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_ovld",  64'(bus.out_valid), 64'd0);
        check_res("rst", 64'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("c1_lowcarry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
               64'h0000_0000_0001_0000, 1'b0, 1'b0);
        run_op("c2_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0,
               64'h0, 1'b1, 1'b0);
        run_op("c3_sub_neg", 64'h5, 64'h7, 1'b1, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        run_op("c3_sub_pos", 64'h7, 64'h5, 1'b0, 1'b1,
               64'h2, 1'b1, 1'b0);
        run_op("c4_ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run_op("c4_ovf_sub", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

        // Backpressure: result must hold while new operands are offered.
        start_op(64'h3, 64'h4, 1'b0, 1'b0);
        wait_result("c5_bp");
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 64'd100;
        bus.b        = 64'd200;
        bus.cin      = 1'b0;
        bus.sub      = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_res("c5_hold", 64'h7, 1'b0, 1'b0);
            chk("c5_hold_rdy",  64'(bus.in_ready), 64'd0);
            chk("c5_hold_ovld", 64'(bus.out_valid), 64'd1);
        end
        release_res("c5_rel");
        start_op(64'd100, 64'd200, 1'b0, 1'b0);
        wait_result("c5_next");
        check_res("c5_next", 64'd300, 1'b0, 1'b0);
        release_res("c5_next");

        // Reset abort after two RUN edges.
        start_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("c6_ovld",  64'(bus.out_valid), 64'd0);
        chk("c6_ready", 64'(bus.in_ready), 64'd1);
        check_res("c6_rst", 64'h0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk("c6_noovld", 64'(bus.out_valid), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op("c6_after", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
               64'h0000_0000_0001_0000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dserial_add64.md
Name: dserial_add64

Overview:
Digit-serial multi-word adder/subtractor built around one cska16 carry-skip adder slice. Latches two NWORDS×16-bit operands through a valid/ready handshake and feeds cska16 one 16-bit slice per cycle, LSW first. Registers the carry between slices and assembles the full-width result with a final carry and a signed-overflow flag. Wide (64-bit default) datapath arithmetic reuses the verified 16-bit skip adder without replicating it.

Parameters:
NWORDS, 4, number of 16-bit slices; total width W = 16*NWORDS; legal range 1..16.

Ports:
Clk  input  1  system clock, rising edge.
Rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand transfer request.
in_ready  output  1  block can accept operands.
A  input  W  operand A.
B  input  W  operand B.
Cin  input  1  carry-in; ignored when Sub=1.
Sub  input  1  0: A+B+Cin; 1: A-B (A + ~B + 1).
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
Sum  output  W  result, registered.
Cout  output  1  carry out of bit W-1.
Ovf  output  1  two's-complement overflow.

Behaviour:
- Reset (Rst_n low, asynchronous): state=IDLE, slice counter=0, carry reg=0, Sum=0, Cout=0, Ovf=0, out_valid=0. No transfer occurs while Rst_n is low.
- FSM states: IDLE, RUN, DONE.
- in_ready = (state==IDLE), combinational from state. out_valid = (state==DONE).
- IDLE, on in_valid at a rising edge:
  - latch A into operand reg; latch B, or ~B if Sub, into operand reg.
  - carry reg <= Sub ? 1 : Cin; counter <= 0; latch sign bits for overflow; state -> RUN.
- RUN, each edge:
  - cska16 computes slice[counter] of A', slice[counter] of B', and carry reg.
  - Sum slice[counter] <= cska16 Sum; carry reg <= cska16 Cout; counter++.
  - On the edge where counter==NWORDS-1: Cout <= cska16 Cout; Ovf <= (A[W-1]==B'[W-1]) && (new Sum[W-1]!=A[W-1]); state -> DONE.
- DONE: Sum, Cout and Ovf hold stable until out_ready=1 at an edge, then state -> IDLE.
- Sum is not cleared between operations. Sum slices are partially updated during RUN; consumers sample only while out_valid=1.
- Latency: out_valid rises NWORDS edges after the accepting edge. Minimum initiation interval is NWORDS+2 cycles (one IDLE cycle is required between operations).
- A, B, Cin and Sub changes after acceptance are ignored. in_valid during RUN or DONE is ignored; it is not queued.
- Wrap-around: the result is modulo 2^W; the carry is visible only on Cout.
- NWORDS=1: RUN lasts exactly one edge.
- Reset mid-RUN or mid-DONE: the operation is aborted, the reset values above apply immediately, and no out_valid pulse follows.

Decomposition:
- Shared package/include: slice width constant (16), FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- Sub-module: a single cska16 instance, port order (Sum, Cout, A, B, Cin). Slice selection uses indexed part-select driven by the counter.
- No other sub-modules.

Test Plan:
1. Carry out of the low word. A=64'h0000_0000_0000_FFFF, B=64'h1, Cin=0, Sub=0 -> Sum=64'h0000_0000_0001_0000, Cout=0, Ovf=0. out_valid rises exactly 4 edges after accept.
2. Full-width ripple. A=64'hFFFF_FFFF_FFFF_FFFF, B=0, Cin=1 -> Sum=0, Cout=1, Ovf=0.
3. Subtract. A=64'h5, B=64'h7, Sub=1, Cin=1 (must be ignored) -> Sum=64'hFFFF_FFFF_FFFF_FFFE, Cout=0, Ovf=0. Repeat with A=7, B=5 -> Sum=2, Cout=1.
4. Signed overflow. A=64'h7FFF_FFFF_FFFF_FFFF, B=1 -> Sum=64'h8000_0000_0000_0000, Ovf=1, Cout=0. Also A=64'h8000_0000_0000_0000, Sub=1, B=1 -> Sum=64'h7FFF_FFFF_FFFF_FFFF, Ovf=1.
5. Backpressure. Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> Sum/Cout/Ovf stable, in_ready=0, new operands not taken. Raise out_ready -> IDLE next edge, in_ready=1, the next operation accepted and its result correct.
6. Reset abort. Drop Rst_n after 2 RUN edges -> out_valid=0, Sum=0, in_ready=1 without waiting for a clock. After release, case 1 still produces the correct result.
